chip8_sprite_drawer: RTL
========================

Name: chip8_sprite_drawer

Overview:
- Executes the CHIP-8 DXYN draw as a bus initiator on the shared memory arbiter's video request port.
- For each sprite row it fetches the sprite byte from RAM at I+row, then read-modify-writes the one or two affected VRAM bytes with XOR.
- Reports the collision flag (VF) and a one-cycle done pulse back to the processor FSM.
- One request is outstanding at a time, so the arbiter's stash-and-retry behaviour never sees back-to-back traffic from this block.

Parameters:
WIDTH, 8, memory data width (fixed at 8 for CHIP-8).
SCREEN_W, 64, screen width in pixels (power of two; VRAM row stride = SCREEN_W/8 bytes).
SCREEN_H, 32, screen height in pixels (power of two).

Ports:
clk_in  input  1  system clock; the only clock.
rst_in  input  1  synchronous, active-high reset.
start_in  input  1  begin draw (sampled only in IDLE).
x_in  input  8  VX value (wrapped mod SCREEN_W at start).
y_in  input  8  VY value (wrapped mod SCREEN_H at start).
n_in  input  4  sprite height in rows.
i_in  input  12  I register, address of sprite row 0.
mem_addr_out  output  12  RAM address or VRAM byte offset.
mem_type_out  output  1  0=RAM, 1=VRAM.
mem_we_out  output  1  write enable.
mem_data_out  output  WIDTH  write data.
mem_valid_out  output  1  request valid.
mem_ready_in  input  1  arbiter can accept; a transfer occurs when valid&&ready.
mem_valid_in  input  1  response strobe (asserted for reads AND writes).
mem_data_in  input  WIDTH  read data, valid with mem_valid_in.
busy_out  output  1  high from start accept until done.
done_out  output  1  one-cycle pulse when the draw is complete.
collision_out  output  1  VF result; valid from done_out until the next start.

Behaviour:
- Reset (synchronous, active-high, applies mid-draw too) sets:
  - state=IDLE;
  - busy_out, done_out, collision_out, mem_valid_out, mem_we_out = 0;
  - mem_addr_out, mem_type_out, mem_data_out = 0.
- No response arriving after a mid-draw reset is consumed.
- Start accept (IDLE with start_in):
  - latch xs=x_in mod SCREEN_W, ys=y_in mod SCREEN_H, n, i;
  - row=0, collision=0; busy_out=1 next cycle.
  - start_in outside IDLE is ignored.
- States: IDLE, FETCH, FETCH_W, LRD, LRD_W, LWR, LWR_W, RRD, RRD_W, RWR, RWR_W, NEXT, DONE.
- Request handshake:
  - in each *_REQ-type state (FETCH, LRD, LWR, RRD, RWR), assert mem_valid_out with stable addr/type/we/data;
  - hold until the cycle mem_ready_in=1, then deassert next cycle and move to the matching _W state;
  - _W waits for mem_valid_in; mem_valid_in in any other state is ignored.
- FETCH: type 0, addr=(i+row) mod 4096, we=0; response is latched as spr.
- Per-row geometry: off=xs[2:0], col=xs[5:3], yr=ys+row.
  - Clipping: if yr>=SCREEN_H, go to DONE (remaining rows are clipped, no requests issued).
  - Left byte: L=spr>>off, VRAM addr = yr*(SCREEN_W/8)+col.
  - Right byte: R=(spr<<(8-off))[7:0], addr+1; issued only if off!=0 and col!=SCREEN_W/8-1 (right edge clips, no wrap).
- LRD reads old byte; LWR writes old^L. collision |= |(old&L). RRD/RWR are identical with R.
- NEXT: row+1; if row+1==n go to DONE, else FETCH.
- n=0: IDLE -> DONE directly, no memory traffic, collision=0.
- DONE: one cycle; done_out=1, collision_out=collision, busy_out=0 on the following cycle; then IDLE.
  - collision_out holds its value until the next accepted start clears it.
- Back-to-back: start_in may be accepted in the cycle after DONE.

Test Plan:
- Ideal memory (ready=1, valid 2 cycles after accept), x=0, y=0, n=1, i=0x050, RAM[0x050]=0xF0, VRAM zero:
  - exactly one fetch of 0x050, read of VRAM 0x00, write of 0xF0 to 0x00; no right-byte access;
  - collision_out=0, done_out pulses once.
- Repeat the same draw: VRAM[0x00] becomes 0x00, collision_out=1.
- Unaligned draw, x=3, y=1, n=1, spr=0xFF:
  - VRAM[0x08]^=0x1F and VRAM[0x09]^=0xE0, in that order.
- Clipping:
  - x=60, spr=0xFF: only byte 7 of the row is written, with 0x0F.
  - y=30, n=5: only rows 30 and 31 are drawn, giving 2 fetches.
  - x=70 wraps to 6.
- Arbiter stall: mem_ready_in held low 5 cycles on every request; mem_valid_out and address stay stable; final VRAM is identical to the ideal case.
- Reset and degenerate cases:
  - rst_in mid-LWR_W: all outputs reach reset values next cycle; a late mem_valid_in is ignored; a fresh start completes correctly.
  - n=0: done_out 1 cycle after start, zero requests issued.

Source files
------------

// File: rtl/chip8_sprite_drawer.sv
// -----------------------------------------------------------------------------
// chip8_sprite_drawer
//
// Executes the CHIP-8 DXYN sprite draw as a bus initiator on the video request
// port of the shared memory arbiter. For every sprite row the byte at I+row is
// fetched from RAM, then the one or two VRAM bytes it overlaps are updated by
// read-modify-write with XOR. Any pixel turned off sets the collision flag (VF).
// Exactly one request is outstanding at any time.
//
// Ports
//   clk_in          system clock
//   rst_in          synchronous, active-high reset (also aborts a draw)
//   start_in        begin a draw; only sampled while idle
//   x_in, y_in      VX / VY, wrapped to the screen at start
//   n_in            sprite height in rows (0 = finish immediately)
//   i_in            address of sprite row 0 in RAM
//   mem_addr_out    RAM address or VRAM byte offset
//   mem_type_out    0 = RAM, 1 = VRAM
//   mem_we_out      write enable
//   mem_data_out    write data
//   mem_valid_out   request valid, held with stable fields until mem_ready_in
//   mem_ready_in    arbiter accepts the request this cycle
//   mem_valid_in    response strobe (reads and writes)
//   mem_data_in     read data, valid with mem_valid_in
//   busy_out        high from start accept until the draw is done
//   done_out        one-cycle pulse at the end of the draw
//   collision_out   VF result, valid from done_out until the next start
// -----------------------------------------------------------------------------
module chip8_sprite_drawer #(
    parameter int WIDTH    = 8,
    parameter int SCREEN_W = 64,
    parameter int SCREEN_H = 32
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             start_in,
    input  logic [7:0]       x_in,
    input  logic [7:0]       y_in,
    input  logic [3:0]       n_in,
    input  logic [11:0]      i_in,
    output logic [11:0]      mem_addr_out,
    output logic             mem_type_out,
    output logic             mem_we_out,
    output logic [WIDTH-1:0] mem_data_out,
    output logic             mem_valid_out,
    input  logic             mem_ready_in,
    input  logic             mem_valid_in,
    input  logic [WIDTH-1:0] mem_data_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             collision_out
);

    localparam int XW        = $clog2(SCREEN_W);
    localparam int YW        = $clog2(SCREEN_H);
    localparam int CW        = XW - 3;
    localparam int AW        = 12;
    localparam int ROW_BYTES = SCREEN_W / 8;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        FETCH_W,
        LRD,
        LRD_W,
        LWR,
        LWR_W,
        RRD,
        RRD_W,
        RWR,
        RWR_W,
        NEXT,
        DONE
    } state_t;

    state_t state_q;
    state_t state_d;

    // Draw context latched at start
    logic [XW-1:0]    xs_q;
    logic [YW-1:0]    ys_q;
    logic [3:0]       n_q;
    logic [AW-1:0]    i_q;
    logic [3:0]       row_q;

    // Current sprite byte and the VRAM byte returned by the last read
    logic [WIDTH-1:0] spr_q;
    logic [WIDTH-1:0] old_q;
    logic             coll_q;

    // Row geometry
    logic [2:0]         off;
    logic [CW-1:0]      col;
    logic [AW-1:0]      yr;
    logic [3:0]         row_next;
    logic [2*WIDTH-1:0] shifted;
    logic [WIDTH-1:0]   l_byte;
    logic [WIDTH-1:0]   r_byte;
    logic [AW-1:0]      left_addr;
    logic [AW-1:0]      right_addr;
    logic               has_right;
    logic               row_clipped;

    // Upper bits of VX/VY are discarded by the screen wrap
    logic unused_in_bits;
    assign unused_in_bits = ^{x_in, y_in};

    assign off      = xs_q[2:0];
    assign col      = xs_q[XW-1:3];
    assign yr       = AW'(ys_q) + AW'(row_q);
    assign row_next = row_q + 4'd1;

    // Shifting the sprite into a double-width window yields the left byte in
    // the upper half and the spill-over into the next byte in the lower half.
    assign shifted = {spr_q, {WIDTH{1'b0}}} >> off;
    assign l_byte  = shifted[2*WIDTH-1:WIDTH];
    assign r_byte  = shifted[WIDTH-1:0];

    assign left_addr  = (yr * AW'(ROW_BYTES)) + AW'(col);
    assign right_addr = left_addr + AW'(1);

    // The right byte is skipped when it holds no pixels or would fall past the
    // right screen edge (sprites clip horizontally, they do not wrap).
    assign has_right   = (off != 3'd0) && !(&col);

    // Next row lies below the bottom edge: the rest of the sprite is clipped
    assign row_clipped = (yr + AW'(1)) >= AW'(SCREEN_H);

    // State register and collision flag (control, reset)
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            coll_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && start_in) begin
                coll_q <= 1'b0;
            end else if (state_q == LRD_W && mem_valid_in) begin
                coll_q <= coll_q | (|(mem_data_in & l_byte));
            end else if (state_q == RRD_W && mem_valid_in) begin
                coll_q <= coll_q | (|(mem_data_in & r_byte));
            end
        end
    end

    // Draw context and data registers (no reset needed, qualified by state)
    always_ff @(posedge clk_in) begin
        if (state_q == IDLE && start_in) begin
            xs_q  <= x_in[XW-1:0];
            ys_q  <= y_in[YW-1:0];
            n_q   <= n_in;
            i_q   <= i_in;
            row_q <= 4'd0;
        end
        if (state_q == FETCH_W && mem_valid_in) begin
            spr_q <= mem_data_in;
        end
        if ((state_q == LRD_W || state_q == RRD_W) && mem_valid_in) begin
            old_q <= mem_data_in;
        end
        if (state_q == NEXT) begin
            row_q <= row_next;
        end
    end

    // Next-state and bus request decode
    always_comb begin
        state_d       = state_q;
        mem_valid_out = 1'b0;
        mem_we_out    = 1'b0;
        mem_type_out  = 1'b0;
        mem_addr_out  = '0;
        mem_data_out  = '0;

        case (state_q)
            IDLE: begin
                if (start_in) begin
                    state_d = (n_in == 4'd0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                mem_valid_out = 1'b1;
                mem_addr_out  = i_q + AW'(row_q);
                if (mem_ready_in) state_d = FETCH_W;
            end
            FETCH_W: begin
                if (mem_valid_in) state_d = LRD;
            end
            LRD: begin
                mem_valid_out = 1'b1;
                mem_type_out  = 1'b1;
                mem_addr_out  = left_addr;
                if (mem_ready_in) state_d = LRD_W;
            end
            LRD_W: begin
                if (mem_valid_in) state_d = LWR;
            end
            LWR: begin
                mem_valid_out = 1'b1;
                mem_type_out  = 1'b1;
                mem_we_out    = 1'b1;
                mem_addr_out  = left_addr;
                mem_data_out  = old_q ^ l_byte;
                if (mem_ready_in) state_d = LWR_W;
            end
            LWR_W: begin
                if (mem_valid_in) state_d = has_right ? RRD : NEXT;
            end
            RRD: begin
                mem_valid_out = 1'b1;
                mem_type_out  = 1'b1;
                mem_addr_out  = right_addr;
                if (mem_ready_in) state_d = RRD_W;
            end
            RRD_W: begin
                if (mem_valid_in) state_d = RWR;
            end
            RWR: begin
                mem_valid_out = 1'b1;
                mem_type_out  = 1'b1;
                mem_we_out    = 1'b1;
                mem_addr_out  = right_addr;
                mem_data_out  = old_q ^ r_byte;
                if (mem_ready_in) state_d = RWR_W;
            end
            RWR_W: begin
                if (mem_valid_in) state_d = NEXT;
            end
            NEXT: begin
                if (row_next == n_q || row_clipped) begin
                    state_d = DONE;
                end else begin
                    state_d = FETCH;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy_out      = (state_q != IDLE);
    assign done_out      = (state_q == DONE);
    assign collision_out = coll_q;

endmodule
